// File: rtl/dice_referee.sv
// Two-player dice referee: locks each player's roll on button release, scores
// the round, holds the result for display and declares a match winner.
module dice_referee #(
  parameter int WIN_SCORE   = 5,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start1,
  input  logic       start2,
  input  logic [3:0] dice1,
  input  logic [3:0] dice2,
  input  logic       new_game,
  output logic [3:0] lock1,
  output logic [3:0] lock2,
  output logic       locked1,
  output logic       locked2,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] last_result,
  output logic       round_done,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [3:0]  WinTarget = 4'(WIN_SCORE);
  localparam logic [15:0] HoldLast  = 16'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    RESULT = 2'd1,
    OVER   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        prev1_q, prev1_d;
  logic        prev2_q, prev2_d;
  logic [3:0]  lock1_q, lock1_d;
  logic [3:0]  lock2_q, lock2_d;
  logic        locked1_q, locked1_d;
  logic        locked2_q, locked2_d;
  logic [3:0]  score1_q, score1_d;
  logic [3:0]  score2_q, score2_d;
  logic [1:0]  last_q, last_d;
  logic        done_q, done_d;
  logic [1:0]  winner_q, winner_d;
  logic [15:0] cnt_q, cnt_d;

  logic       fall1, fall2;
  logic [3:0] score1_inc, score2_inc;

  assign fall1      = prev1_q & ~start1;
  assign fall2      = prev2_q & ~start2;
  assign score1_inc = score1_q + 4'd1;
  assign score2_inc = score2_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    prev1_d   = start1;
    prev2_d   = start2;
    lock1_d   = lock1_q;
    lock2_d   = lock2_q;
    locked1_d = locked1_q;
    locked2_d = locked2_q;
    score1_d  = score1_q;
    score2_d  = score2_q;
    last_d    = last_q;
    done_d    = 1'b0;
    winner_d  = winner_q;
    cnt_d     = cnt_q;

    case (state_q)
      WAIT: begin
        if (locked1_q && locked2_q) begin
          done_d = 1'b1;
          cnt_d  = 16'd0;
          if (lock1_q > lock2_q) begin
            score1_d = score1_inc;
            last_d   = 2'b01;
            if (score1_inc == WinTarget) begin
              state_d  = OVER;
              winner_d = 2'b01;
            end else begin
              state_d = RESULT;
            end
          end else if (lock2_q > lock1_q) begin
            score2_d = score2_inc;
            last_d   = 2'b10;
            if (score2_inc == WinTarget) begin
              state_d  = OVER;
              winner_d = 2'b10;
            end else begin
              state_d = RESULT;
            end
          end else begin
            last_d  = 2'b11;
            state_d = RESULT;
          end
        end else begin
          if (fall1 && !locked1_q) begin
            lock1_d   = dice1;
            locked1_d = 1'b1;
          end
          if (fall2 && !locked2_q) begin
            lock2_d   = dice2;
            locked2_d = 1'b1;
          end
        end
      end
      RESULT: begin
        // The display hold ends by clearing the round's locks on the same edge.
        if (cnt_q == HoldLast) begin
          state_d   = WAIT;
          lock1_d   = 4'd0;
          lock2_d   = 4'd0;
          locked1_d = 1'b0;
          locked2_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      OVER: begin
      end
      default: begin
        state_d = WAIT;
      end
    endcase

    // A new match overrides whatever the state machine decided this cycle,
    // including a scoring edge; the edge detectors keep tracking the buttons.
    if (new_game) begin
      state_d   = WAIT;
      lock1_d   = 4'd0;
      lock2_d   = 4'd0;
      locked1_d = 1'b0;
      locked2_d = 1'b0;
      score1_d  = 4'd0;
      score2_d  = 4'd0;
      last_d    = 2'b00;
      done_d    = 1'b0;
      winner_d  = 2'b00;
      cnt_d     = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT;
      prev1_q   <= 1'b0;
      prev2_q   <= 1'b0;
      lock1_q   <= 4'd0;
      lock2_q   <= 4'd0;
      locked1_q <= 1'b0;
      locked2_q <= 1'b0;
      score1_q  <= 4'd0;
      score2_q  <= 4'd0;
      last_q    <= 2'b00;
      done_q    <= 1'b0;
      winner_q  <= 2'b00;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      prev1_q   <= prev1_d;
      prev2_q   <= prev2_d;
      lock1_q   <= lock1_d;
      lock2_q   <= lock2_d;
      locked1_q <= locked1_d;
      locked2_q <= locked2_d;
      score1_q  <= score1_d;
      score2_q  <= score2_d;
      last_q    <= last_d;
      done_q    <= done_d;
      winner_q  <= winner_d;
      cnt_q     <= cnt_d;
    end
  end

  assign lock1       = lock1_q;
  assign lock2       = lock2_q;
  assign locked1     = locked1_q;
  assign locked2     = locked2_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign last_result = last_q;
  assign round_done  = done_q;
  assign game_over   = (state_q == OVER);
  assign winner      = winner_q;

endmodule

// File: tb/tb_dice_referee.sv
// Self-checking bench for dice_referee: a table of rounds scored through a
// queue of expected results, plus hand-written reset/new_game corner cases.
module tb_dice_referee;

  localparam int WinScore   = 3;
  localparam int HoldCycles = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start2;
  logic [3:0] dice1, dice2;
  logic       new_game;
  logic [3:0] lock1, lock2;
  logic       locked1, locked2;
  logic [3:0] score1, score2;
  logic [1:0] last_result;
  logic       round_done;
  logic       game_over;
  logic [1:0] winner;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    logic [3:0] d1;
    logic [3:0] d2;
    logic       simul;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] lr;
    logic       go;
    logic [1:0] w;
  } vec_t;

  typedef struct {
    logic [3:0] l1;
    logic [3:0] l2;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] lr;
    logic       go;
    logic [1:0] w;
  } exp_t;

  vec_t vecs[7];
  exp_t sbQ[$];

  dice_referee #(
    .WIN_SCORE  (WinScore),
    .HOLD_CYCLES(HoldCycles)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start1     (start1),
    .start2     (start2),
    .dice1      (dice1),
    .dice2      (dice2),
    .new_game   (new_game),
    .lock1      (lock1),
    .lock2      (lock2),
    .locked1    (locked1),
    .locked2    (locked2),
    .score1     (score1),
    .score2     (score2),
    .last_result(last_result),
    .round_done (round_done),
    .game_over  (game_over),
    .winner     (winner)
  );

  // 10-unit clock; all driving and sampling happens on the falling edge.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " lock1"}, lock1, 0);
    checkOutput({tag, " lock2"}, lock2, 0);
    checkOutput({tag, " locked"}, {locked1, locked2}, 0);
    checkOutput({tag, " score1"}, score1, 0);
    checkOutput({tag, " score2"}, score2, 0);
    checkOutput({tag, " last_result"}, last_result, 0);
    checkOutput({tag, " round_done"}, round_done, 0);
    checkOutput({tag, " game_over"}, game_over, 0);
    checkOutput({tag, " winner"}, winner, 0);
  endtask

  task automatic pushExpect(input logic [3:0] l1, input logic [3:0] l2,
                            input logic [3:0] s1, input logic [3:0] s2,
                            input logic [1:0] lr, input logic go, input logic [1:0] w);
    exp_t e;
    e.l1 = l1; e.l2 = l2; e.s1 = s1; e.s2 = s2; e.lr = lr; e.go = go; e.w = w;
    sbQ.push_back(e);
  endtask

  // Plays one table row from WAIT; ends on the falling edge where both locks are visible.
  task automatic applyStimulus(input vec_t v);
    pushExpect(v.d1, v.d2, v.s1, v.s2, v.lr, v.go, v.w);
    if (v.simul) begin
      start1 = 1'b1; start2 = 1'b1;
      tick;
      start1 = 1'b0; start2 = 1'b0; dice1 = v.d1; dice2 = v.d2;
      tick;
      checkOutput("simultaneous locks", {locked1, locked2}, 3);
      checkOutput("simultaneous lock1", lock1, v.d1);
      checkOutput("simultaneous lock2", lock2, v.d2);
      checkOutput("round_done not early", round_done, 0);
    end else begin
      start1 = 1'b1;
      tick;
      start1 = 1'b0; dice1 = v.d1;
      tick;
      checkOutput("lock1 value", lock1, v.d1);
      checkOutput("locked2 still low", locked2, 0);
      dice1 = 4'd9 - v.d1;
      start2 = 1'b1;
      tick;
      start2 = 1'b0; dice2 = v.d2;
      tick;
      checkOutput("lock1 held", lock1, v.d1);
      checkOutput("lock2 value", lock2, v.d2);
      checkOutput("round_done not early", round_done, 0);
    end
    dice2 = 4'd9 - v.d2;
  endtask

  // Waits (bounded) for the scoring pulse and compares it against the queue head.
  task automatic waitRound;
    int   n = 0;
    bit   seen = 1'b0;
    exp_t e;
    while (n < 10 && !seen) begin
      tick;
      n++;
      if (round_done === 1'b1) seen = 1'b1;
    end
    checkOutput("round_done seen", int'(seen), 1);
    checkOutput("scoreboard not empty", sbQ.size(), sbQ.size() == 0 ? 1 : sbQ.size());
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      if (seen) begin
        checkOutput("scoring latency", n, 1);
        checkOutput("round lock1", lock1, e.l1);
        checkOutput("round lock2", lock2, e.l2);
        checkOutput("round score1", score1, e.s1);
        checkOutput("round score2", score2, e.s2);
        checkOutput("round last_result", last_result, e.lr);
        checkOutput("round game_over", game_over, e.go);
        checkOutput("round winner", winner, e.w);
      end
    end
  endtask

  initial begin
    vecs[0] = '{4'd7, 4'd4, 1'b0, 4'd1, 4'd0, 2'b01, 1'b0, 2'b00};
    vecs[1] = '{4'd5, 4'd5, 1'b1, 4'd1, 4'd0, 2'b11, 1'b0, 2'b00};
    vecs[2] = '{4'd2, 4'd8, 1'b0, 4'd1, 4'd1, 2'b10, 1'b0, 2'b00};
    vecs[3] = '{4'd9, 4'd0, 1'b0, 4'd2, 4'd1, 2'b01, 1'b0, 2'b00};
    vecs[4] = '{4'd0, 4'd0, 1'b1, 4'd2, 4'd1, 2'b11, 1'b0, 2'b00};
    vecs[5] = '{4'd3, 4'd9, 1'b1, 4'd2, 4'd2, 2'b10, 1'b0, 2'b00};
    vecs[6] = '{4'd6, 4'd9, 1'b0, 4'd2, 4'd3, 2'b10, 1'b1, 2'b10};

    rst = 1'b1; new_game = 1'b0;
    start1 = 1'b1; start2 = 1'b0;
    dice1 = 4'd0; dice2 = 4'd0;
    tick;
    tick;
    checkAllZero("reset");

    // start1 held high across reset release: no lock until it is released.
    rst = 1'b0;
    tick;
    tick;
    checkOutput("held through reset no lock", locked1, 0);
    start1 = 1'b0; dice1 = 4'd6;
    tick;
    checkOutput("held through reset lock1", lock1, 6);
    checkOutput("held through reset locked1", locked1, 1);
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    checkAllZero("new_game in WAIT");

    // Match from the table; start1 is pressed mid-hold and held across re-entry.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      waitRound();
      if (!vecs[i].go) begin
        for (int c = 2; c <= HoldCycles; c++) begin
          tick;
          if (c == 2) begin
            checkOutput("round_done single cycle", round_done, 0);
            start1 = 1'b1;
          end
          checkOutput("locked during hold", {locked1, locked2}, 3);
        end
        tick;
        checkOutput("locks cleared after hold", {locked1, locked2}, 0);
        checkOutput("lock values cleared", {lock1, lock2}, 0);
        checkOutput("last_result persists", last_result, vecs[i].lr);
        checkOutput("held button no relock", locked1, 0);
      end
    end

    // OVER: button activity is ignored and everything stays frozen.
    start1 = 1'b1; start2 = 1'b1;
    tick;
    checkOutput("over round_done cleared", round_done, 0);
    start1 = 1'b0; start2 = 1'b0; dice1 = 4'd9; dice2 = 4'd1;
    for (int c = 0; c < 6; c++) begin
      tick;
      checkOutput("over no round_done", round_done, 0);
    end
    checkOutput("over lock1 frozen", lock1, 6);
    checkOutput("over lock2 frozen", lock2, 9);
    checkOutput("over scores frozen", {score1, score2}, {4'd2, 4'd3});
    checkOutput("over game_over", game_over, 1);
    checkOutput("over winner", winner, 2);
    checkOutput("over last_result", last_result, 2);
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    checkAllZero("new_game from OVER");

    // Re-release after locking is ignored.
    start1 = 1'b1;
    tick;
    start1 = 1'b0; dice1 = 4'd2;
    tick;
    checkOutput("first lock1", lock1, 2);
    start1 = 1'b1; dice1 = 4'd9;
    tick;
    start1 = 1'b0;
    tick;
    checkOutput("re-release ignored", lock1, 2);
    pushExpect(4'd2, 4'd3, 4'd0, 4'd1, 2'b10, 1'b0, 2'b00);
    start2 = 1'b1;
    tick;
    start2 = 1'b0; dice2 = 4'd3;
    tick;
    waitRound();

    // rst on the second RESULT cycle cancels the hold.
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkAllZero("rst mid-RESULT");
    start1 = 1'b1;
    tick;
    start1 = 1'b0; dice1 = 4'd4;
    tick;
    checkOutput("WAIT after rst lock1", lock1, 4);
    pushExpect(4'd4, 4'd1, 4'd1, 4'd0, 2'b01, 1'b0, 2'b00);
    start2 = 1'b1;
    tick;
    start2 = 1'b0; dice2 = 4'd1;
    tick;
    waitRound();

    // new_game on the second RESULT cycle does the same.
    tick;
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    checkAllZero("new_game mid-RESULT");
    start1 = 1'b1;
    tick;
    start1 = 1'b0; dice1 = 4'd5;
    tick;
    checkOutput("WAIT after new_game lock1", lock1, 5);

    // new_game on the scoring edge wins: no score, no pulse.
    start2 = 1'b1;
    tick;
    start2 = 1'b0; dice2 = 4'd2;
    tick;
    checkOutput("both locked before clash", {locked1, locked2}, 3);
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    checkAllZero("new_game on scoring edge");
    tick;
    checkOutput("no late round_done", round_done, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
